memory_unloader: RTL and testbench
==================================

// Module: memory_unloader
// PURPOSE
//   Reads the 64-page x 25-bit lane memory back out and reassembles the 1600-bit
//   Keccak state: the inverse of the 1600-bit-to-page load path. Sits beside the
//   page memory; drives its page address while the encoder datapath is idle and
//   hands the flat state to the output/compare logic with a valid/ack handshake.
// PARAMETERS
//   PAGES    64    number of memory pages (z depth); counter wraps at PAGES-1
//   LANE_W   25    bits per page (5x5 slice); state width = PAGES*LANE_W = 1600
//   PAGE_W   6     page address width, clog2(PAGES)
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   start        in   1       request an unload; sampled only in IDLE or DONE
//   stall        in   1       freeze page counter/capture (memory shared this cycle)
//   mem_data     in   LANE_W  combinational read data = mem[page]
//   page         out  PAGE_W  page address driven to memory
//   busy         out  1       high while state != IDLE
//   state_out    out  1600    reassembled state
//   state_valid  out  1       state_out complete; held until state_ack
//   state_ack    in   1       consumer accepted state_out
//   checksum     out  LANE_W  XOR of all captured pages (MEMORY_UNLOADER_CHECKSUM_EN only)
// BEHAVIOUR
//   - Bit mapping (fixed): state_out[64*(5*y+x)+z] = page z, bit (5*y+x), x,y in 0..4.
//   - rst: state=IDLE, page=0, busy=0, state_valid=0, state_out=0, checksum=0.
//   - FSM IDLE -> READ -> DONE -> IDLE.
//   - IDLE: edge with start=1 -> READ, page<=0. Otherwise hold.
//   - READ, stall=1: page, state_out, checksum unchanged.
//   - READ, stall=0: write mem_data into lane `page` of state_out (same edge,
//     memory read is combinational); if page==PAGES-1 -> DONE, state_valid<=1,
//     page<=0; else page<=page+1. No wrap beyond PAGES-1.
//   - start during READ is ignored (no restart, no queue).
//   - DONE: state_valid held 1, state_out stable. state_ack=1 -> state_valid<=0;
//     if start=1 on same edge -> READ page 0 (back-to-back), else IDLE.
//     start without state_ack in DONE is ignored.
//   - Latency: start edge = edge 1; with no stall state_valid rises at edge 65.
//     Each stalled cycle in READ adds exactly one cycle.
//   - state_out is not cleared at start; every bit is overwritten during READ.
//   - Module never writes memory; page is its only memory-side output.
//   - rst mid-READ/DONE: immediate return to reset values, partial data discarded.
// CONFIGURATION
//   MEMORY_UNLOADER_CHECKSUM_EN defined: checksum cleared on the start edge,
//     checksum <= checksum ^ mem_data on every non-stalled READ capture; stable
//     while state_valid=1.
//   Not defined: checksum port and its register absent; all else identical.
// TESTING
//   1 Assert rst mid-sim -> page=0, busy=0, state_valid=0, state_out=0 immediately.
//   2 Memory model loaded with state bit k = (k%3==0); pulse start, no stall ->
//     page steps 0..63, state_valid at edge 65, state_out equals source vector.
//   3 Same, stall=1 for 10 cycles when page==20 -> page holds 20, state_valid at
//     edge 75, state_out identical to scenario 2.
//   4 start re-pulsed at page 30 -> ignored, page continues 31, valid still edge 65.
//   5 In DONE raise state_ack+start together -> state_valid 0 next edge, page=0,
//     busy=1, second unload completes 64 edges later; rst at page 40 -> all reset.
//   6 CHECKSUM_EN, mem[z]=z (z=0..63) -> checksum = XOR(0..63) = 0; mem[5]=25'h1FFFFFF
//     only nonzero page -> checksum = 25'h1FFFFFF.

Source files
------------

// File: rtl/memory_unloader_if.sv
// Handshake/bus bundle between the memory unloader, its page memory and the state consumer.
// The checksum signal exists only when MEMORY_UNLOADER_CHECKSUM_EN is defined.
interface memory_unloader_if #(
  parameter int PAGES  = 64,
  parameter int LANE_W = 25,
  parameter int PAGE_W = 6
);
  logic                      start;
  logic                      stall;
  logic [LANE_W-1:0]         mem_data;
  logic [PAGE_W-1:0]         page;
  logic                      busy;
  logic [PAGES*LANE_W-1:0]   state_out;
  logic                      state_valid;
  logic                      state_ack;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
  logic [LANE_W-1:0]         checksum;
`endif

  // Controller / memory / consumer side
  modport master (
    output start, stall, mem_data, state_ack,
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
    input  checksum,
`endif
    input  page, busy, state_out, state_valid
  );

  // Unloader side
  modport slave (
    input  start, stall, mem_data, state_ack,
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
    output checksum,
`endif
    output page, busy, state_out, state_valid
  );
endinterface

// File: rtl/memory_unloader.sv
// Walks the page memory and reassembles the flat Keccak state (page z, bit b -> state_out[PAGES*b+z]).
// Optional running XOR checksum of captured pages when MEMORY_UNLOADER_CHECKSUM_EN is defined.
module memory_unloader #(
  parameter int PAGES  = 64,
  parameter int LANE_W = 25,
  parameter int PAGE_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  memory_unloader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES - 1);

  state_t                    fsm_q, fsm_d;
  logic [PAGE_W-1:0]         page_q, page_d;
  logic                      valid_q, valid_d;
  logic [PAGES*LANE_W-1:0]   state_out_q, state_out_d;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
  logic [LANE_W-1:0]         checksum_q, checksum_d;
`endif

  always_comb begin
    fsm_d       = fsm_q;
    page_d      = page_q;
    valid_d     = valid_q;
    state_out_d = state_out_q;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          fsm_d  = READ;
          page_d = '0;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      READ: begin
        if (!bus.stall) begin
          // Memory read is combinational, so the current page's data lands on this edge.
          for (int b = 0; b < LANE_W; b++) begin
            state_out_d[b*PAGES + int'(page_q)] = bus.mem_data[b];
          end
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
          checksum_d = checksum_q ^ bus.mem_data;
`endif
          if (page_q == LAST_PAGE) begin
            fsm_d   = DONE;
            valid_d = 1'b1;
            page_d  = '0;
          end else begin
            page_d  = page_q + PAGE_W'(1);
          end
        end
      end
      DONE: begin
        // A start is honoured only together with the ack, giving back-to-back unloads.
        if (bus.state_ack) begin
          valid_d = 1'b0;
          if (bus.start) begin
            fsm_d  = READ;
            page_d = '0;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
            checksum_d = '0;
`endif
          end else begin
            fsm_d  = IDLE;
          end
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      page_q      <= '0;
      valid_q     <= 1'b0;
      state_out_q <= '0;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      page_q      <= page_d;
      valid_q     <= valid_d;
      state_out_q <= state_out_d;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign bus.page        = page_q;
  assign bus.busy        = (fsm_q != IDLE);
  assign bus.state_valid = valid_q;
  assign bus.state_out   = state_out_q;
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
  assign bus.checksum    = checksum_q;
`endif

endmodule

// File: tb/tb_memory_unloader.sv
// Scoreboard bench for memory_unloader: stimulus queues expected unloads, a monitor checks each valid rise.
module tb_memory_unloader;

  localparam int PAGES  = 64;
  localparam int LANE_W = 25;
  localparam int PAGE_W = 6;
  localparam int SW     = PAGES * LANE_W;

  typedef struct {
    logic [SW-1:0]     state;
    int                edge_no;
    logic [LANE_W-1:0] cks;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  memory_unloader_if #(.PAGES(PAGES), .LANE_W(LANE_W), .PAGE_W(PAGE_W)) bus ();

  memory_unloader #(.PAGES(PAGES), .LANE_W(LANE_W), .PAGE_W(PAGE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [LANE_W-1:0] mem [PAGES];
  logic [SW-1:0]     src;
  exp_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                edge_cnt = 0;
  logic              valid_seen = 1'b0;

  assign bus.mem_data = mem[bus.page];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_state(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
    int nbad;
    int first;
    nbad  = 0;
    first = -1;
    for (int k = 0; k < SW; k++) begin
      if (act[k] !== req[k]) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL %s actual differs in %0d bits (first bit %0d = %b) required bit = %b",
               name, nbad, first, act[first], req[first]);
    end else begin
      $display("ok   %s matches", name);
    end
  endtask

  // Monitor: one comparison set per rising state_valid
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      valid_seen = 1'b0;
    end else begin
      if (bus.state_valid && !valid_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 required=0 at edge %0d", edge_cnt);
        end else begin
          e = exp_q.pop_front();
          chk_state("state_out", bus.state_out, e.state);
          chk("valid_edge", edge_cnt, e.edge_no);
`ifdef MEMORY_UNLOADER_CHECKSUM_EN
          chk("checksum", 32'(bus.checksum), 32'(e.cks));
`endif
        end
      end
      valid_seen = bus.state_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_from_src();
    for (int z = 0; z < PAGES; z++)
      for (int b = 0; b < LANE_W; b++)
        mem[z][b] = src[PAGES*b + z];
  endtask

  task automatic src_from_mem();
    for (int z = 0; z < PAGES; z++)
      for (int b = 0; b < LANE_W; b++)
        src[PAGES*b + z] = mem[z][b];
  endtask

  // Start edge is edge 1; valid rises 64 + stall edges later.
  task automatic do_start(input int stalls, input logic [LANE_W-1:0] cks);
    exp_t e;
    e.state   = src;
    e.edge_no = edge_cnt + 1 + PAGES + stalls;
    e.cks     = cks;
    exp_q.push_back(e);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_valid required=valid within 300 cycles", name);
      exp_q.delete();
    end
  endtask

  task automatic wait_page(input logic [PAGE_W-1:0] p);
    int n;
    n = 0;
    while (bus.page !== p && n < 200) begin
      tick();
      n++;
    end
    if (bus.page !== p) begin
      checks++;
      errors++;
      $display("FAIL wait_page actual=%0d required=%0d", bus.page, p);
    end
  endtask

  task automatic do_ack();
    bus.state_ack = 1'b1;
    tick();
    bus.state_ack = 1'b0;
    chk("ack_valid", 32'(bus.state_valid), 32'd0);
    chk("ack_busy", 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [LANE_W-1:0] xor_pages();
    logic [LANE_W-1:0] x;
    x = '0;
    for (int z = 0; z < PAGES; z++) x ^= mem[z];
    return x;
  endfunction

  initial begin
    logic [SW-1:0] zero_state;
    zero_state    = '0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.state_ack = 1'b0;
    for (int k = 0; k < SW; k++) src[k] = (k % 3 == 0);
    mem_from_src();

    repeat (2) tick();
    chk("rst_page", 32'(bus.page), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.state_valid), 32'd0);
    chk_state("rst_state", bus.state_out, zero_state);
    rst = 1'b0;
    tick();

    // Plain unload, then a start without ack in DONE must be ignored
    do_start(0, xor_pages());
    chk("read_busy", 32'(bus.busy), 32'd1);
    wait_done("plain");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("done_noack_valid", 32'(bus.state_valid), 32'd1);
    chk("done_noack_page", 32'(bus.page), 32'd0);
    chk("done_noack_busy", 32'(bus.busy), 32'd1);
    do_ack();

    // Ten stall cycles at page 20
    do_start(10, xor_pages());
    wait_page(6'd20);
    bus.stall = 1'b1;
    repeat (10) tick();
    chk("stall_page_hold", 32'(bus.page), 32'd20);
    bus.stall = 1'b0;
    wait_done("stall");
    do_ack();

    // Re-pulsed start at page 30 is ignored
    do_start(0, xor_pages());
    wait_page(6'd30);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_ignored_page", 32'(bus.page), 32'd31);
    wait_done("restart");
    do_ack();

    // Back-to-back via ack+start in DONE, then async reset mid-READ
    do_start(0, xor_pages());
    wait_done("b2b_first");
    bus.state_ack = 1'b1;
    do_start(0, xor_pages());
    bus.state_ack = 1'b0;
    chk("b2b_valid", 32'(bus.state_valid), 32'd0);
    chk("b2b_page", 32'(bus.page), 32'd0);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b_second");
    do_ack();

    do_start(0, xor_pages());
    wait_page(6'd40);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_page", 32'(bus.page), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_valid", 32'(bus.state_valid), 32'd0);
    chk_state("midrst_state", bus.state_out, zero_state);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    repeat (70) tick();
    chk("post_rst_idle_valid", 32'(bus.state_valid), 32'd0);

`ifdef MEMORY_UNLOADER_CHECKSUM_EN
    // mem[z]=z: XOR of 0..63 is 0
    for (int z = 0; z < PAGES; z++) mem[z] = LANE_W'(z);
    src_from_mem();
    do_start(0, 25'h0);
    wait_done("cks_ramp");
    do_ack();
    // Single all-ones page at z=5
    for (int z = 0; z < PAGES; z++) mem[z] = '0;
    mem[5] = 25'h1FFFFFF;
    src_from_mem();
    do_start(0, 25'h1FFFFFF);
    wait_done("cks_single");
    do_ack();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
